uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Parametrised UART receiver, next generation of the board's fixed 8N1 receiver. It oversamples the RX line, detects the start bit with false-start rejection, majority-votes each bit, and supports 5–9 data bits, optional odd/even parity and 1 or 2 stop bits. Received words leave through a one-entry valid/ready holding register, with per-word parity and framing flags and a sticky overrun flag. It sits between the board serial pins and the command/telemetry logic, all in the `clk` domain.

## Interface
- `CLK_DIV`, default 13: `clk` cycles per oversample tick, ≥2; baud = f_clk / (CLK_DIV·OVERSAMPLE).
- `OVERSAMPLE`, default 16: ticks per bit; 8 or 16 only.
- `DATA_BITS`, default 8: data bits per frame, 5–9.
- `PARITY`, default PARITY_NONE: PARITY_NONE, PARITY_ODD or PARITY_EVEN.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk` in 1: module clock.
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: asynchronous UART line, idle high.
- `data` out DATA_BITS: received word, LSB = first data bit on the line.
- `valid` out 1: holding register full.
- `ready` in 1: consumer accepts `data` on `clk` edges where `valid && ready`.
- `parity_err` out 1: parity mismatch for the word in `data`; 0 when PARITY_NONE.
- `frame_err` out 1: a stop bit sampled low for the word in `data`.
- `overrun` out 1: sticky; at least one completed frame was dropped.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) and then a 3-deep sample shift register updated on each tick. A bit value is the majority of the three most recent samples.
- The tick generator is free-running. In IDLE it restarts on a synchronized falling edge so that tick phase aligns to the start edge.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE → START on a synchronized 1→0 edge of `rx`.
  - START: at tick OVERSAMPLE/2 the bit is voted. A vote of 1 is a false start → IDLE. A vote of 0 → DATA, and the bit counter is cleared.
  - DATA: vote at mid-bit every OVERSAMPLE ticks and shift in LSB-first. After DATA_BITS bits → PARITY if PARITY ≠ NONE, else STOP.
  - PARITY: vote one bit. Error if the XOR of data and parity bit ≠ (PARITY==ODD).
  - STOP: vote STOP_BITS bits. Any 0 sets the frame error. At the mid-point of the last stop bit the frame completes: → IDLE if the vote was 1, else → WAIT_HIGH.
  - WAIT_HIGH: stay until synchronized `rx` = 1, then → IDLE. A held break yields exactly one word.
- Frame completion:
  - Holding register empty, or being read in the same cycle (`valid && ready`): load `data`, `parity_err`, `frame_err`; set `valid`.
  - Holding register full and not being read: drop the frame, set `overrun`; the register is unchanged.
- `overrun` clears on the first `valid && ready` after it was set, unless a new drop happens in that same cycle; the set wins.
- Reset mid-frame abandons the frame. The FSM goes to IDLE and the holding register is cleared.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, FSM=IDLE.
- The tick is a 1-cycle enable every CLK_DIV cycles; there are no derived clocks.
- Edge detect latency: 2 `clk` cycles after the `rx` transition (synchronizer).
- `valid` rises 1 `clk` after the tick that votes the last stop bit. From the start-edge crossing that is (1+DATA_BITS+P+STOP_BITS−½)·OVERSAMPLE·CLK_DIV + 3 cycles, ±1, where P = 0/1.
- `valid` falls on the edge after a `valid && ready` cycle, unless a new word loads in that same edge, in which case it stays high.
- `data` and flags are stable while `valid` is high.
- The receiver tolerates ±3 % baud mismatch at OVERSAMPLE=16.

## Structure
- Package `uart_pkg`: `parity_t` enum (PARITY_NONE/ODD/EVEN) and `rx_state_t` enum. The package is shared with the future transmitter.
- Sub-module `uart_tick_gen` (CLK_DIV parameter; `clk`, `reset`, `restart`, `tick`) is reusable by the transmitter.
- The FSM, voter and holding register live in `uart_rx_oversampled`.

## Test plan
- **8N1 clean frame.** CLK_DIV=4, OVERSAMPLE=16. Send 0xA5 with `ready`=1 → `valid` pulses once, `data`=0xA5, no flags, latency within ±1 cycle of formula.
- **False start.** A 3-tick low glitch on `rx` → no `valid`. A following 0x3C frame is received correctly.
- **Parity.** 7E1: send 0x41 with a correct parity bit → `parity_err`=0; send it again with the parity bit flipped → `parity_err`=1, `data`=0x41.
- **Framing/break.** Hold `rx` low for 3 frame times → exactly one word, `data`=0, `frame_err`=1. The next word arrives only after `rx` returns high.
- **Overrun.** `ready`=0, send 0x11 then 0x22 → `data`=0x11, `overrun`=1. Raise `ready` for 1 cycle → `valid`=0, `overrun`=0.
- **Reset mid-frame.** Assert `reset` during data bit 4 → all outputs 0 immediately. A subsequent 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the future transmitter.
//   parity_t   : frame parity mode
//   rx_state_t : receiver FSM states
//   maj3       : 2-of-3 majority vote used for bit decisions
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator.
//   clk, reset : module clock, asynchronous active-high reset
//   restart    : re-phase the divider; next tick comes CLK_DIV cycles later
//   tick       : registered 1-cycle enable, once every CLK_DIV cycles
module uart_tick_gen #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned    CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Preload 1 on restart: tick is registered, so this lands it exactly
  // CLK_DIV cycles after the restart cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= CNT_W'(1);
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with majority vote, 5-9 data bits, optional
// parity, 1-2 stop bits and a one-entry valid/ready holding register.
//   clk, reset  : module clock, asynchronous active-high reset
//   rx          : asynchronous serial line, idle high
//   data, valid : received word (LSB first on the line) and holding-full flag
//   ready       : consumer accepts data when valid && ready
//   parity_err  : parity mismatch for the held word
//   frame_err   : a stop bit of the held word was sampled low
//   overrun     : sticky, a completed frame was dropped
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 13,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_t     PARITY     = PARITY_NONE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned       TC_W      = $clog2(OVERSAMPLE);
  localparam int unsigned       BC_W      = 4;
  localparam logic [TC_W-1:0]   MID_TICK  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0]   LAST_DATA = BC_W'(DATA_BITS - 1);
  localparam logic [BC_W-1:0]   LAST_STOP = BC_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == PARITY_ODD);

  logic rx_meta, rx_sync, rx_prev;
  logic fall, restart, tick, mid, vote, rd, done;

  rx_state_t            state, state_nxt;
  logic [1:0]           samples, samples_nxt;
  logic [TC_W-1:0]      tick_cnt, tick_cnt_nxt;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt, data_nxt;
  logic                 par_acc, par_nxt, ferr_acc, ferr_nxt;
  logic                 valid_nxt, perr_out_nxt, ferr_out_nxt, overrun_nxt;

  // Line synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall    = rx_prev & ~rx_sync;
  assign restart = (state == RX_IDLE) && fall;
  assign mid     = tick && (tick_cnt == MID_TICK);
  assign rd      = valid && ready;
  // Two stored samples plus the one taken on this tick form the vote window.
  assign vote    = maj3({samples, rx_sync});

  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      samples    <= 2'b11;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      ferr_acc   <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      samples    <= samples_nxt;
      tick_cnt   <= tick_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_acc    <= par_nxt;
      ferr_acc   <= ferr_nxt;
      data       <= data_nxt;
      valid      <= valid_nxt;
      parity_err <= perr_out_nxt;
      frame_err  <= ferr_out_nxt;
      overrun    <= overrun_nxt;
    end
  end

  // Next-state, bit assembly and holding-register control.
  always_comb begin
    state_nxt    = state;
    samples_nxt  = samples;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_nxt      = par_acc;
    ferr_nxt     = ferr_acc;
    data_nxt     = data;
    valid_nxt    = valid;
    perr_out_nxt = parity_err;
    ferr_out_nxt = frame_err;
    overrun_nxt  = overrun;
    done         = 1'b0;

    if (tick) begin
      samples_nxt  = {samples[0], rx_sync};
      tick_cnt_nxt = tick_cnt + TC_W'(1);
    end

    case (state)
      RX_IDLE: begin
        if (fall) begin
          state_nxt    = RX_START;
          tick_cnt_nxt = '0;
          par_nxt      = 1'b0;
          ferr_nxt     = 1'b0;
        end
      end
      RX_START: begin
        if (mid) begin
          if (vote) begin
            state_nxt = RX_IDLE;
          end else begin
            state_nxt   = RX_DATA;
            bit_cnt_nxt = '0;
          end
        end
      end
      RX_DATA: begin
        if (mid) begin
          shreg_nxt   = {vote, shreg[DATA_BITS-1:1]};
          bit_cnt_nxt = bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (mid) begin
          par_nxt   = ((^shreg) ^ vote) != PAR_ODD;
          state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (mid) begin
          ferr_nxt    = ferr_acc | ~vote;
          bit_cnt_nxt = bit_cnt + BC_W'(1);
          if (bit_cnt == LAST_STOP) begin
            done      = 1'b1;
            state_nxt = vote ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A held break must not retrigger until the line recovers.
        if (rx_sync) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase

    if (rd) begin
      valid_nxt   = 1'b0;
      overrun_nxt = 1'b0;
    end

    // A read in the same cycle frees the register for the new word.
    if (done) begin
      if (!valid || rd) begin
        data_nxt     = shreg;
        valid_nxt    = 1'b1;
        perr_out_nxt = par_acc;
        ferr_out_nxt = ferr_nxt;
      end else begin
        overrun_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench: an 8N1 receiver (a) and a 7E1 receiver (b) driven with
// directed and randomized serial frames, checked against a frame decoder model.
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned OS      = 16;
  localparam int unsigned BIT_T   = CLK_DIV * OS;
  localparam int unsigned DA      = 8;
  localparam int unsigned DB      = 7;
  localparam int          LAT_EXP = ((2 * (1 + 8 + 0 + 1) - 1) * 16 * 4) / 2 + 3;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rx_a, ready_a, valid_a, perr_a, ferr_a, ovr_a;
  logic rx_b, ready_b, valid_b, perr_b, ferr_b, ovr_b;
  logic [DA-1:0] data_a;
  logic [DB-1:0] data_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int words_a = 0;
  int words_b = 0;
  int rise_a  = -1;
  logic valid_a_q = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_oversampled #(
    .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(DA),
    .PARITY(PARITY_NONE), .STOP_BITS(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data(data_a), .valid(valid_a),
    .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a)
  );

  uart_rx_oversampled #(
    .CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(DB),
    .PARITY(PARITY_EVEN), .STOP_BITS(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .data(data_b), .valid(valid_b),
    .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line levels of one frame, bit 0 first: start, data LSB first, parity, stop.
  function automatic logic [15:0] build_line(input logic [8:0] d, input int nd,
                                             input parity_t par, input logic flip,
                                             input logic bad_stop);
    logic [15:0] l;
    int ones;
    int np;
    logic pbit;
    l    = '1;
    ones = 0;
    np   = (par != PARITY_NONE) ? 1 : 0;
    l[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      l[1 + i] = d[i];
      ones += int'(d[i]);
    end
    if (np == 1) begin
      pbit = (par == PARITY_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0);
      l[1 + nd] = pbit ^ flip;
    end
    l[1 + nd + np] = ~bad_stop;
    return l;
  endfunction

  // Reference decoder: what a receiver must report for a given line image.
  function automatic exp_t decode(input logic [15:0] l, input int nd, input parity_t par);
    exp_t r;
    int ones;
    int np;
    r.data = '0;
    ones   = 0;
    np     = (par != PARITY_NONE) ? 1 : 0;
    for (int i = 0; i < nd; i++) begin
      r.data[i] = l[1 + i];
      ones += int'(l[1 + i]);
    end
    r.perr = 1'b0;
    if (np == 1) begin
      ones += int'(l[1 + nd]);
      r.perr = (par == PARITY_EVEN) ? (ones % 2 != 0) : (ones % 2 != 1);
    end
    r.ferr = ~l[1 + nd + np];
    return r;
  endfunction

  task automatic send(input bit sel, input logic [15:0] l, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      if (sel) rx_b = l[i]; else rx_a = l[i];
      cycles(period);
    end
    if (sel) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic frame(input bit sel, input logic [8:0] d, input logic flip,
                       input logic bad_stop, input int period, input bit expect_it);
    logic [15:0] l;
    int nd;
    int n;
    parity_t par;
    nd  = sel ? int'(DB) : int'(DA);
    par = sel ? PARITY_EVEN : PARITY_NONE;
    l   = build_line(d, nd, par, flip, bad_stop);
    n   = 2 + nd + ((par != PARITY_NONE) ? 1 : 0);
    if (expect_it) begin
      if (sel) exp_b.push_back(decode(l, nd, par));
      else     exp_a.push_back(decode(l, nd, par));
    end
    send(sel, l, n, period);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!reset && valid_a && ready_a) begin
      check("a_word_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        check("a_data", 32'(data_a), 32'(e.data));
        check("a_parity_err", 32'(perr_a), 32'(e.perr));
        check("a_frame_err", 32'(ferr_a), 32'(e.ferr));
      end
      words_a++;
    end
    if (valid_a && !valid_a_q) rise_a = cyc;
    valid_a_q = valid_a;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset && valid_b && ready_b) begin
      check("b_word_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        check("b_data", 32'(data_b), 32'(e.data));
        check("b_parity_err", 32'(perr_b), 32'(e.perr));
        check("b_frame_err", 32'(ferr_b), 32'(e.ferr));
      end
      words_b++;
    end
  end

  initial begin
    int t0;
    int lat;
    int w0;
    logic [15:0] l;

    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    cycles(3);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_perr_a", 32'(perr_a), 32'd0);
    check("rst_ferr_a", 32'(ferr_a), 32'd0);
    check("rst_ovr_a", 32'(ovr_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_ovr_b", 32'(ovr_b), 32'd0);
    reset = 1'b0;
    cycles(5);

    // Clean 8N1 frame and its latency from the start edge.
    rise_a = -1;
    t0 = cyc;
    frame(1'b0, 9'h0A5, 1'b0, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    lat = rise_a - t0;
    check("a_latency", 32'((lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) ? LAT_EXP : lat),
          32'(LAT_EXP));
    check("a_words_clean", 32'(words_a), 32'd1);

    // 3-tick glitch is rejected, next frame still decodes.
    w0 = words_a;
    rx_a = 1'b0;
    cycles(3 * CLK_DIV);
    rx_a = 1'b1;
    cycles(2 * BIT_T);
    check("a_false_start", 32'(words_a - w0), 32'd0);
    frame(1'b0, 9'h03C, 1'b0, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    check("a_after_glitch", 32'(words_a - w0), 32'd1);

    // 7E1 parity: correct then flipped parity bit.
    frame(1'b1, 9'h041, 1'b0, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    frame(1'b1, 9'h041, 1'b1, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    check("b_words_parity", 32'(words_b), 32'd2);

    // Break for 3 frame times gives exactly one zero word with frame error.
    w0 = words_a;
    exp_a.push_back(decode(16'h0000, DA, PARITY_NONE));
    rx_a = 1'b0;
    cycles(30 * BIT_T);
    check("a_break_words", 32'(words_a - w0), 32'd1);
    rx_a = 1'b1;
    cycles(2 * BIT_T);
    check("a_break_release", 32'(words_a - w0), 32'd1);
    frame(1'b0, 9'h077, 1'b0, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    check("a_after_break", 32'(words_a - w0), 32'd2);

    // Overrun: second word dropped while the first is held.
    ready_a = 1'b0;
    frame(1'b0, 9'h011, 1'b0, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    frame(1'b0, 9'h022, 1'b0, 1'b0, BIT_T, 1'b0);
    cycles(BIT_T);
    check("ovr_valid", 32'(valid_a), 32'd1);
    check("ovr_data", 32'(data_a), 32'h11);
    check("ovr_flag", 32'(ovr_a), 32'd1);
    ready_a = 1'b1;
    cycles(1);
    ready_a = 1'b0;
    check("ovr_valid_after_read", 32'(valid_a), 32'd0);
    check("ovr_flag_after_read", 32'(ovr_a), 32'd0);

    // Reset during data bit 4 clears a held word and abandons the frame.
    frame(1'b0, 9'h066, 1'b0, 1'b0, BIT_T, 1'b0);
    cycles(BIT_T);
    check("pre_reset_valid", 32'(valid_a), 32'd1);
    l = build_line(9'h05A, DA, PARITY_NONE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rx_a = l[i];
      cycles(BIT_T);
    end
    rx_a = l[5];
    cycles(BIT_T / 2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    check("mid_rst_data", 32'(data_a), 32'd0);
    check("mid_rst_perr", 32'(perr_a), 32'd0);
    check("mid_rst_ferr", 32'(ferr_a), 32'd0);
    check("mid_rst_ovr", 32'(ovr_a), 32'd0);
    @(posedge clk);
    #1;
    cycles(2);
    reset = 1'b0;
    rx_a = 1'b1;
    cycles(2 * BIT_T);
    w0 = words_a;
    ready_a = 1'b1;
    cycles(BIT_T);
    check("post_rst_no_word", 32'(words_a - w0), 32'd0);
    frame(1'b0, 9'h05A, 1'b0, 1'b0, BIT_T, 1'b1);
    cycles(BIT_T);
    check("post_rst_word", 32'(words_a - w0), 32'd1);

    // Randomized frames with up to about 3% baud error.
    for (int k = 0; k < 8; k++) begin
      frame(1'b0, 9'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 7) == 0),
            $urandom_range(62, 66), 1'b1);
      cycles($urandom_range(BIT_T, 2 * BIT_T));
    end
    for (int k = 0; k < 6; k++) begin
      frame(1'b1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), $urandom_range(62, 66), 1'b1);
      cycles($urandom_range(BIT_T, 2 * BIT_T));
    end
    cycles(BIT_T);
    check("a_pending", 32'(exp_a.size()), 32'd0);
    check("b_pending", 32'(exp_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
